// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions for the receiver and the transmitter test top.
// Timing values are in 25 MHz clock cycles (40 ns).
//   T0H / T1H       : high time of a transmitted 0 / 1 bit
//   TBIT            : full bit period
//   T_THRESH        : high length at or above which a bit decodes as 1
//   T_HIGH_MAX      : longest legal high length
//   T_RESET         : low length that latches a frame
//   state_t         : receiver FSM states
package ws2812_pkg;

  localparam int T0H        = 10;
  localparam int T1H        = 20;
  localparam int TBIT       = 31;
  localparam int T_THRESH   = 15;
  localparam int T_HIGH_MAX = 50;
  localparam int T_RESET    = 1250;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/ws2812_sync.sv
// Brings the asynchronous WS2812 line into the clk domain and detects edges.
// Ports:
//   clk      in  system clock
//   n_reset  in  synchronous active-low reset
//   din      in  raw serial line
//   level    out synchronized line level
//   rise     out synchronized level went 0 -> 1 this cycle
//   fall     out synchronized level went 1 -> 0 this cycle
module ws2812_sync (
  input  logic clk,
  input  logic n_reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Edges come from registered samples only, so the FSM acts on them
  // two clock edges after the line level is first sampled.
  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver. Classifies each bit by its high-pulse width,
// assembles 24-bit words MSB first and flags frame ends on the latch gap.
// Ports:
//   clk          in   system clock (25 MHz)
//   n_reset      in   synchronous active-low reset
//   din          in   WS2812 serial data, asynchronous
//   pixel_data   out  last completed word, first bit in [23]
//   pixel_valid  out  one-cycle strobe with pixel_data / pixel_index
//   pixel_index  out  0-based pixel position in the current frame
//   frame_done   out  one-cycle strobe on the latch gap
//   frame_len    out  complete pixels in the frame just ended
//   err          out  one-cycle strobe on a protocol error
//   busy         out  high while inside a frame (HIGH or LOW)
// Handshake: pixel_valid, frame_done and err are single-cycle strobes with
// no back-pressure; their data outputs hold until the next strobe.
// CW must satisfy 2**CW > T_RESET.
module ws2812_rx #(
  parameter int T_THRESH   = ws2812_pkg::T_THRESH,
  parameter int T_HIGH_MAX = ws2812_pkg::T_HIGH_MAX,
  parameter int T_RESET    = ws2812_pkg::T_RESET,
  parameter int CW         = 11
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        err,
  output logic        busy
);

  import ws2812_pkg::*;

  logic level, rise, fall;

  ws2812_sync u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [4:0]    bit_cnt, bit_cnt_d;
  logic [23:0]   shreg, shreg_d, word;
  logic [7:0]    idx, idx_d;
  logic          new_bit;

  logic [23:0]   pixel_data_d;
  logic          pixel_valid_d;
  logic [7:0]    pixel_index_d;
  logic          frame_done_d;
  logic [7:0]    frame_len_d;
  logic          err_d;

  // cnt_inc is the run length including the current cycle; it saturates.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign new_bit = (cnt_inc >= CW'(T_THRESH));
  assign word    = {shreg[22:0], new_bit};
  assign busy    = (state == HIGH) || (state == LOW);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= SYNC;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      idx         <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_cnt     <= bit_cnt_d;
      shreg       <= shreg_d;
      idx         <= idx_d;
      pixel_data  <= pixel_data_d;
      pixel_valid <= pixel_valid_d;
      pixel_index <= pixel_index_d;
      frame_done  <= frame_done_d;
      frame_len   <= frame_len_d;
      err         <= err_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bit_cnt_d     = bit_cnt;
    shreg_d       = shreg;
    idx_d         = idx;
    pixel_data_d  = pixel_data;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len;
    err_d         = 1'b0;

    case (state)
      // Wait for a full latch-length low run so a stream joined
      // mid-frame is never decoded.
      SYNC: begin
        if (level) begin
          cnt_d = '0;
        end else if (cnt_inc >= CW'(T_RESET)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end

      // The overlong check comes first so a pulse one cycle too long
      // is rejected even when its falling edge arrives in that cycle.
      HIGH: begin
        if (cnt_inc > CW'(T_HIGH_MAX)) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          cnt_d     = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
          idx_d     = '0;
        end else if (fall) begin
          state_d = LOW;
          cnt_d   = '0;
          shreg_d = word;
          if (bit_cnt == 5'd23) begin
            pixel_data_d  = word;
            pixel_valid_d = 1'b1;
            pixel_index_d = idx;
            idx_d         = idx + 8'd1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // LOW is only entered after a bit was shifted in, so every frame
      // ending here has at least one bit and frame_done always fires.
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_inc >= CW'(T_RESET)) begin
          frame_done_d = 1'b1;
          frame_len_d  = idx;
          err_d        = (bit_cnt != 5'd0);
          idx_d        = '0;
          bit_cnt_d    = '0;
          shreg_d      = '0;
          state_d      = IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = SYNC;
    endcase
  end

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;
  import ws2812_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic        err;
  logic        busy;

  always #20 clk = ~clk;

  ws2812_rx dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .err         (err),
    .busy        (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int frames_seen = 0;
  int err_seen = 0;
  int err_with_done = 0;
  logic [31:0] exp_q[$];      // {index, data}
  logic [7:0]  exp_len_q[$];

  typedef struct {
    int   hi;
    int   lo;
    logic bit_v;
  } thr_vec_t;

  thr_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    din = 1'b1;
    wait_cyc(hi);
    din = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(T1H, TBIT - T1H);
    else   send_pulse(T0H, TBIT - T0H);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic expect_pixel(input logic [7:0] index, input logic [23:0] data);
    exp_q.push_back({index, data});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pixel_data"},  32'(pixel_data),  32'd0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_pixel_index"}, 32'(pixel_index), 32'd0);
    check({tag, "_frame_done"},  32'(frame_done),  32'd0);
    check({tag, "_frame_len"},   32'(frame_len),   32'd0);
    check({tag, "_err"},         32'(err),         32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  task automatic end_test(input string tag, input int exp_frames, input int exp_errs,
                          input int exp_err_done);
    check({tag, "_pixels_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_frames_pending"}, 32'(exp_len_q.size()), 32'd0);
    check({tag, "_frame_count"}, 32'(frames_seen), 32'(exp_frames));
    check({tag, "_err_count"}, 32'(err_seen), 32'(exp_errs));
    check({tag, "_err_with_done"}, 32'(err_with_done), 32'(exp_err_done));
    exp_q.delete();
    exp_len_q.delete();
    frames_seen   = 0;
    err_seen      = 0;
    err_with_done = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      check("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("pixel_word", {pixel_index, pixel_data}, exp_q.pop_front());
      check("valid_done_overlap", 32'(frame_done), 32'd0);
    end
    if (frame_done === 1'b1) begin
      frames_seen++;
      check("frame_expected", 32'(exp_len_q.size() != 0), 32'd1);
      if (exp_len_q.size() != 0) check("frame_len", 32'(frame_len), 32'(exp_len_q.pop_front()));
      if (err === 1'b1) err_with_done++;
    end
    if (err === 1'b1) err_seen++;
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{14, 17, 1'b0};
    vecs[1] = '{15, 16, 1'b1};
    vecs[2] = '{16, 15, 1'b1};
    vecs[3] = '{50, 11, 1'b1};
    vecs[4] = '{10, 21, 1'b0};
    vecs[5] = '{20, 11, 1'b1};

    // Reset values
    n_reset = 1'b0;
    din     = 1'b0;
    wait_cyc(3);
    check_reset_values("reset");
    n_reset = 1'b1;

    // Startup: latch-length low, then one pixel
    wait_cyc(1250);
    expect_pixel(8'd0, 24'h00FF00);
    send_word(24'h00FF00);
    exp_len_q.push_back(8'd1);
    wait_cyc(1300);
    end_test("startup", 1, 0, 0);

    // Multi-pixel frame with stalls between pixels
    for (int p = 0; p < 16; p++) begin
      logic [23:0] w;
      w = (p % 2 == 0) ? 24'hFF00FF : 24'hFF0000;
      expect_pixel(8'(p), w);
      send_word(w);
      if (p == 0) check("busy_in_frame", 32'(busy), 32'd1);
      if (p < 15) wait_cyc(800);
    end
    exp_len_q.push_back(8'd16);
    wait_cyc(1300);
    check("busy_after_frame", 32'(busy), 32'd0);
    end_test("multi", 1, 0, 0);

    // Threshold table: each row is one pixel of 24 identical bits
    for (int r = 0; r < 6; r++) begin
      expect_pixel(8'(r), vecs[r].bit_v ? 24'hFFFFFF : 24'h000000);
      repeat (24) send_pulse(vecs[r].hi, vecs[r].lo);
    end
    exp_len_q.push_back(8'd6);
    wait_cyc(1300);
    end_test("threshold", 1, 0, 0);

    // Overlong high pulse: error, then nothing until a latch-length low
    send_pulse(51, 20);
    check("busy_after_err", 32'(busy), 32'd0);
    send_word(24'hABCDEF);
    wait_cyc(1300);
    expect_pixel(8'd0, 24'h123456);
    send_word(24'h123456);
    exp_len_q.push_back(8'd1);
    wait_cyc(1300);
    end_test("overlong", 1, 1, 0);

    // Mid-frame join: reset released while the line is toggling
    fork
      send_word(24'hFFFFFF);
      begin
        wait_cyc(100);
        n_reset = 1'b0;
        wait_cyc(3);
        n_reset = 1'b1;
      end
    join
    send_word(24'h0F0F0F);
    wait_cyc(1300);
    expect_pixel(8'd0, 24'hA5A5A5);
    send_word(24'hA5A5A5);
    exp_len_q.push_back(8'd1);
    wait_cyc(1300);
    end_test("midjoin", 1, 0, 0);

    // Partial word: 30 bits then the latch gap
    expect_pixel(8'd0, 24'hC3A511);
    send_word(24'hC3A511);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exp_len_q.push_back(8'd1);
    wait_cyc(1300);
    end_test("partial", 1, 1, 1);

    // Reset mid-pixel: one reset cycle after 12 bits
    for (int i = 23; i >= 12; i--) send_bit(i[0]);
    n_reset = 1'b0;
    wait_cyc(1);
    check_reset_values("reset_mid");
    n_reset = 1'b1;
    for (int i = 11; i >= 0; i--) send_bit(i[0]);
    wait_cyc(1300);
    end_test("reset_mid_stale", 0, 0, 0);
    expect_pixel(8'd0, 24'h5A5A5A);
    send_word(24'h5A5A5A);
    exp_len_q.push_back(8'd1);
    wait_cyc(1300);
    end_test("reset_mid_recover", 1, 0, 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Decoder for the single-wire WS2812 LED protocol, i.e. the receiving end of the PIO-driven WS2812 transmitter. Samples an asynchronous serial line and classifies each bit by its high-pulse width. Outputs every received 24-bit pixel word with a one-cycle strobe and a running pixel index. Flags frame boundaries on the latch (reset) gap. Used on the ULX3S top for loopback self-test of PIO programs and for sniffing LED chains.

## Interface

Parameters:
- T_THRESH, 15: high-pulse length in cycles at or above which a bit decodes as 1. At 25 MHz, 0.6 us.
- T_HIGH_MAX, 50: high-pulse length in cycles above which the pulse is a protocol error (2 us).
- T_RESET, 1250: low length in cycles that ends a frame (50 us).
- CW, 11: width of the pulse counter. It must satisfy 2^CW > T_RESET.

Ports:
- clk  in  1  system clock (25 MHz).
- n_reset  in  1  synchronous, active-low reset.
- din  in  1  WS2812 serial data, asynchronous to clk.
- pixel_data  out  24  last completed word, first-received bit in [23] (GRB order on the wire).
- pixel_valid  out  1  one-cycle strobe; pixel_data/pixel_index valid this cycle.
- pixel_index  out  8  position of the pixel in the current frame, 0-based, wraps mod 256.
- frame_done  out  1  one-cycle strobe on latch gap after ≥1 bit received.
- frame_len  out  8  number of complete pixels in the frame just ended (mod 256); valid with frame_done, held otherwise.
- err  out  1  one-cycle strobe on protocol error.
- busy  out  1  high while in a frame (FSM in HIGH or LOW).

## Operation

- din passes through a 2-flop synchronizer, then a registered rising/falling edge detector.
- States:
  - SYNC: after reset and after any error. Counts consecutive low cycles. A low run of T_RESET cycles goes to IDLE. Any high cycle clears the count. A stream joined mid-frame is therefore ignored.
  - IDLE: waits for a rising edge. On the edge, clear the counter and go to HIGH.
  - HIGH: counts cycles. If the count exceeds T_HIGH_MAX, pulse err, discard the partial word, go to SYNC. On a falling edge, shift in bit = (count ≥ T_THRESH), clear the counter, go to LOW.
  - LOW: counts cycles. A rising edge goes to HIGH. When the count reaches T_RESET, end the frame and go to IDLE.
- Word assembly:
  - 5-bit bit counter and 24-bit shift register, MSB first.
  - On the 24th bit, load pixel_data, assert pixel_valid, present pixel_index, increment the index and clear the bit counter.
- Frame end:
  - If the bit counter is ≠ 0, pulse err and drop the partial word. frame_done still pulses.
  - frame_len = pixel index; then clear the index.
  - frame_done is not pulsed if the frame contained zero bits. This case cannot occur from IDLE.
- Low gaps between bits or pixels shorter than T_RESET are legal and do not break a frame, because the transmitter may stall on an empty FIFO.
- Counters saturate at all-ones and never wrap.

## Timing

- Reset values: pixel_data=0, pixel_valid=0, pixel_index=0, frame_done=0, frame_len=0, err=0, busy=0. FSM=SYNC. Counters=0.
- n_reset is sampled on the clk edge. Asserting it mid-pixel discards all partial state. After release, the block requires a full T_RESET low run before it decodes.
- Latency, let t be the first rising clk edge at which din is sampled with a new level:
  - The edge is seen by the FSM at edge t+2.
  - pixel_valid, err and frame_done are registered and are high in the cycle after edge t+2, for exactly one cycle.
- Pulse widths are measured on the synchronized signal. The measured width equals the true width ±1 cycle.
  - A high count of exactly T_THRESH decodes as 1.
  - A high count of exactly T_HIGH_MAX is legal.
- pixel_valid and frame_done never coincide: a frame ends ≥T_RESET cycles after the last bit.
- err may coincide with frame_done when a partial word is dropped at frame end.

## Structure

- Package ws2812_pkg:
  - default timing constants: T0H=10, T1H=20, TBIT=31, T_THRESH, T_HIGH_MAX, T_RESET;
  - the state enum (SYNC, IDLE, HIGH, LOW).
  - The transmitter test top and this block share it.
- Sub-module ws2812_sync: 2-flop synchronizer plus registered edge detector. Outputs level, rise, fall.
- The remainder (FSM, counters, shifter) lives in ws2812_rx.

## Test plan

- Startup:
  - Stimulus: release n_reset with din low for 1250 cycles, then 24 bits of 0x00FF00 (0 = 10 high/21 low; 1 = 20 high/11 low), then 1250 low.
  - Required response: pixel_valid once with 0x00FF00, index 0. Then frame_done with frame_len=1. err never asserts.
- Multi-pixel frame:
  - Stimulus: 16 pixels alternating 0xFF00FF00-derived 0xFF00FF / 0xFF0000, with 800-cycle low gaps between pixels.
  - Required response: 16 strobes, indices 0..15, frame_done with frame_len=16.
- Threshold boundaries:
  - Stimulus: high widths 14, 15, 16, 50, 51 cycles.
  - Required response: decode as 0, 1, 1, 1. The 51-cycle pulse gives err and a return to SYNC; no pixel until the next 1250-cycle low.
- Mid-frame join:
  - Stimulus: release n_reset while din is toggling mid-frame.
  - Required response: no pixel_valid until a 1250-cycle low run, then normal decode.
- Partial word:
  - Stimulus: 30 bits, then the latch gap.
  - Required response: one pixel_valid; err and frame_done in the same cycle; frame_len=1.
- Reset mid-pixel:
  - Stimulus: n_reset=0 for one cycle after 12 bits.
  - Required response: all outputs return to their reset values the next cycle; no stale word is emitted later.
